load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage between the multicycle datapath and a variable-latency, word-organised data memory.
- Accepts one load or store per handshake, encoded with RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Performs alignment checks, byte-lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns one response per request; the datapath stalls its memory state until the response arrives.

Parameters:
- ADDR_W, 32: byte-address width of req_addr and mem_addr.
- TIMEOUT, 255: cycles to wait for mem_ack before aborting with an error; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign (RV32I load/store funct3).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (low bits are used for SB/SH).
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory access request; held until acked.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read word; valid only when mem_ack=1.
- mem_ack  in  1  memory completion; may assert in the first mem_req cycle.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_err=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; timeout counter=0.
  - Reset asserted mid-access drops mem_req immediately. No response is ever produced for the aborted request.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE:
  - req_ready=1. A transfer occurs when req_valid && req_ready.
  - On transfer, latch addr, funct3, wdata and write; clear the counter.
  - Legal funct3: loads 0, 1, 2, 4, 5; stores 0, 1, 2.
  - Alignment: half accesses need addr[0]=0; word accesses need addr[1:0]=0.
  - Illegal or misaligned request -> RESP with err=1. No memory access is made.
  - Legal load -> READ. SW -> WRITE with mem_wdata=wdata. SB/SH -> RMW_READ.
- READ:
  - mem_req=1, mem_we=0.
  - On mem_ack: extract the lane selected by addr[1:0] and extend it.
    - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: whole word.
  - Register the result into resp_data -> RESP.
- RMW_READ:
  - mem_req=1, mem_we=0.
  - On mem_ack: merge wdata[7:0] (SB) or wdata[15:0] (SH) into the lane of mem_rdata selected by addr; all other lanes are preserved.
  - Load the merged word into mem_wdata -> WRITE.
- WRITE: mem_req=1, mem_we=1; on mem_ack -> RESP with resp_data=0.
- mem_addr and mem_wdata are stable for every cycle mem_req=1.
- Timeout:
  - The counter increments each memory-state cycle without mem_ack and clears on entering each memory state.
  - When counter reaches TIMEOUT-1 with no ack: drop mem_req -> RESP with err=1, resp_data=0.
  - A timeout in RMW_READ never issues the write.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE. resp_valid is not back-pressured.
- Outside READ, RMW_READ and WRITE, mem_ack and mem_rdata are ignored.
- Latency with a zero-wait memory, measured from the transfer cycle to the resp_valid cycle:
  - load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error detected at request: 1 cycle.
- Throughput: at most one outstanding request; the next transfer is possible in the cycle after RESP.

Decomposition:
- Add to params.v:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - LSU state encodings.
- One combinational sub-module, lsu_lane_align:
  - inputs: funct3, addr[1:0], word, wdata.
  - outputs: extended load data and merged store word.
  - Shared by the READ and RMW_READ paths.

Test Plan:
- Zero-wait LB: mem word 0x80FF7F01 at 0x100, addr 0x102 -> mem_addr=0x100; resp_data=0xFFFFFFFF; resp_valid exactly 2 cycles after transfer.
- LHU and LH: same word, addr 0x102 -> LHU gives 0x000080FF, LH gives 0xFFFF80FF.
- SB with 3-wait memory: memory holds 0x11223344, addr 0x201, wdata 0xAB -> read held 4 cycles, then write 0x1122AB44, then resp_err=0.
- Misaligned: LW at 0x102 or SH at 0x203 -> no mem_req; resp_valid with err=1 one cycle after transfer. Illegal load funct3=3 -> same response.
- TIMEOUT=8, memory never acks -> mem_req high for 8 cycles, then err=1. For SB, mem_we is never asserted.
- reset_n pulsed low during WRITE wait -> mem_req=0 asynchronously, no resp_valid, req_ready=1. A following LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Holds funct3 encodings, FSM states and the request legality check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } lsuState_t;

  // Legal funct3 for the direction and naturally aligned for the size.
  function automatic logic reqLegal(
    input logic       write,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic legal;
    logic aligned;
    if (write)
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'd1:    aligned = !off[0];
      2'd2:    aligned = (off == 2'd0);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for
// sub-word stores; purely combinational.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] storeWord
);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    shamt = {addr, 3'b000};
    lane  = word >> shamt;
    loadData = lane;
    unique case (1'b1)
      (funct3 == F3_B):  loadData = {{24{lane[7]}}, lane[7:0]};
      (funct3 == F3_H):  loadData = {{16{lane[15]}}, lane[15:0]};
      (funct3 == F3_BU): loadData = {24'd0, lane[7:0]};
      (funct3 == F3_HU): loadData = {16'd0, lane[15:0]};
      default:           loadData = lane;
    endcase
  end

  always_comb begin
    mask = 32'hFFFF_FFFF;
    unique case (1'b1)
      (funct3[1:0] == 2'd0): mask = 32'h0000_00FF << shamt;
      (funct3[1:0] == 2'd1): mask = 32'h0000_FFFF << shamt;
      default:               mask = 32'hFFFF_FFFF;
    endcase
    storeWord = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store in flight against a
// variable-latency word memory, with RMW for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  lsuState_t state, nextState;

  logic [2:0]       f3Q;
  logic [1:0]       offQ;
  logic [31:0]      wdataQ;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             reqOk;
  logic             memState;
  logic             timedOut;
  logic [31:0]      loadData;
  logic [31:0]      storeWord;

  assign xfer     = req_valid && req_ready;
  assign reqOk    = reqLegal(req_write, req_funct3, req_addr[1:0]);
  assign memState = state inside {S_READ, S_RMW_READ, S_WRITE};
  assign timedOut = (TIMEOUT != 0) && memState && !mem_ack &&
                    (cnt == CNT_W'(TIMEOUT - 1));

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_req    = memState;
  assign mem_we     = (state == S_WRITE);

  lsu_lane_align uAlign (
    .funct3    (f3Q),
    .addr      (offQ),
    .word      (mem_rdata),
    .wdata     (wdataQ),
    .loadData  (loadData),
    .storeWord (storeWord)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          if (!reqOk)               nextState = S_RESP;
          else if (!req_write)      nextState = S_READ;
          else if (req_funct3 == F3_W) nextState = S_WRITE;
          else                      nextState = S_RMW_READ;
        end
      end
      S_READ:
        if (mem_ack || timedOut) nextState = S_RESP;
      S_RMW_READ: begin
        if (mem_ack)       nextState = S_WRITE;
        else if (timedOut) nextState = S_RESP;
      end
      S_WRITE:
        if (mem_ack || timedOut) nextState = S_RESP;
      S_RESP:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f3Q       <= '0;
      offQ      <= '0;
      wdataQ    <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (xfer) begin
        f3Q       <= req_funct3;
        offQ      <= req_addr[1:0];
        wdataQ    <= req_wdata;
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        resp_data <= '0;
        resp_err  <= !reqOk;
        if (req_write) mem_wdata <= req_wdata;
      end
      if (state == S_READ && mem_ack)
        resp_data <= loadData;
      if (state == S_RMW_READ && mem_ack)
        mem_wdata <= storeWord;
      if (timedOut)
        resp_err <= 1'b1;
      // Counter restarts on every entry into a memory state.
      if (xfer || (state == S_RMW_READ && mem_ack))
        cnt <= '0;
      else if (memState && !mem_ack)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small
// word memory model with programmable wait states.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] memArr [0:255];
  int          waitCycles = 0;
  logic        noAck = 1'b0;
  int          waitCnt = 0;
  logic        pokeEn = 1'b0;
  logic [7:0]  pokeIdx = '0;
  logic [31:0] pokeData = '0;

  int          reqCycles = 0;
  int          weCycles = 0;
  int          respCount = 0;
  logic [31:0] lastMemAddr = '0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  assign mem_rdata = memArr[mem_addr[9:2]];
  assign mem_ack   = mem_req && !noAck && (waitCnt == waitCycles);

  always @(posedge clock) begin
    if (pokeEn) memArr[pokeIdx] <= pokeData;
    if (mem_req && mem_we && mem_ack)
      memArr[mem_addr[9:2]] <= mem_wdata;
    if (!mem_req || mem_ack) waitCnt <= 0;
    else                     waitCnt <= waitCnt + 1;
  end

  always @(posedge clock) begin
    if (mem_req) begin
      reqCycles   <= reqCycles + 1;
      lastMemAddr <= mem_addr;
    end
    if (mem_req && mem_we) weCycles <= weCycles + 1;
    if (resp_valid) respCount <= respCount + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    pokeEn = 1'b1;
    pokeIdx = a[9:2];
    pokeData = d;
    @(negedge clock);
    pokeEn = 1'b0;
  endtask

  task automatic runReq(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] d,
                        output logic e);
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 0;
    d = '0;
    e = 1'b0;
    for (int i = 1; i < 40; i++) begin
      if (i > 1) begin
        @(posedge clock);
        #1;
      end
      if (resp_valid) begin
        lat = i;
        d = resp_data;
        e = resp_err;
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    check("pulse", 32'(resp_valid), 32'd0);
  endtask

  int          lat;
  logic [31:0] d;
  logic        e;
  int          rq0, we0, rs0;

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_mwe", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    check("rst_rdata", resp_data, 32'd0);
    check("rst_rerr", 32'(resp_err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    poke(32'h100, 32'h80FF7F01);
    poke(32'h200, 32'h11223344);

    runReq(1'b0, 3'd0, 32'h102, '0, lat, d, e);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_data", d, 32'hFFFFFFFF);
    check("lb_err", 32'(e), 32'd0);
    check("lb_maddr", lastMemAddr, 32'h100);
    runReq(1'b0, 3'd5, 32'h102, '0, lat, d, e);
    check("lhu_data", d, 32'h000080FF);
    runReq(1'b0, 3'd1, 32'h102, '0, lat, d, e);
    check("lh_data", d, 32'hFFFF80FF);
    runReq(1'b0, 3'd4, 32'h101, '0, lat, d, e);
    check("lbu_data", d, 32'h0000007F);
    runReq(1'b0, 3'd0, 32'h103, '0, lat, d, e);
    check("lb3_data", d, 32'hFFFFFF80);
    runReq(1'b0, 3'd2, 32'h100, '0, lat, d, e);
    check("lw_data", d, 32'h80FF7F01);
    check("lw_lat", 32'(lat), 32'd2);

    waitCycles = 3;
    rq0 = reqCycles;
    we0 = weCycles;
    runReq(1'b1, 3'd0, 32'h201, 32'h000000AB, lat, d, e);
    check("sb_lat", 32'(lat), 32'd9);
    check("sb_err", 32'(e), 32'd0);
    check("sb_data", d, 32'd0);
    check("sb_rdcyc", 32'((reqCycles - rq0) - (weCycles - we0)), 32'd4);
    check("sb_wecyc", 32'(weCycles - we0), 32'd4);
    check("sb_mem", memArr[128], 32'h1122AB44);

    waitCycles = 0;
    runReq(1'b1, 3'd1, 32'h202, 32'h1234BEEF, lat, d, e);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_mem", memArr[128], 32'hBEEFAB44);
    runReq(1'b1, 3'd2, 32'h204, 32'hDEADBEEF, lat, d, e);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_mem", memArr[129], 32'hDEADBEEF);

    rq0 = reqCycles;
    runReq(1'b0, 3'd2, 32'h102, '0, lat, d, e);
    check("mis_lw_lat", 32'(lat), 32'd1);
    check("mis_lw_err", 32'(e), 32'd1);
    check("mis_lw_data", d, 32'd0);
    runReq(1'b1, 3'd1, 32'h203, 32'hFFFF, lat, d, e);
    check("mis_sh_lat", 32'(lat), 32'd1);
    check("mis_sh_err", 32'(e), 32'd1);
    runReq(1'b0, 3'd3, 32'h100, '0, lat, d, e);
    check("ill_ld_lat", 32'(lat), 32'd1);
    check("ill_ld_err", 32'(e), 32'd1);
    runReq(1'b1, 3'd4, 32'h200, '0, lat, d, e);
    check("ill_st_err", 32'(e), 32'd1);
    check("err_nomreq", 32'(reqCycles - rq0), 32'd0);
    check("sh_kept", memArr[128], 32'hBEEFAB44);

    noAck = 1'b1;
    rq0 = reqCycles;
    runReq(1'b0, 3'd2, 32'h100, '0, lat, d, e);
    check("to_lw_cyc", 32'(reqCycles - rq0), 32'd8);
    check("to_lw_err", 32'(e), 32'd1);
    check("to_lw_data", d, 32'd0);
    check("to_lw_lat", 32'(lat), 32'd9);
    rq0 = reqCycles;
    we0 = weCycles;
    runReq(1'b1, 3'd0, 32'h201, 32'h55, lat, d, e);
    check("to_sb_cyc", 32'(reqCycles - rq0), 32'd8);
    check("to_sb_we", 32'(weCycles - we0), 32'd0);
    check("to_sb_err", 32'(e), 32'd1);
    check("to_sb_mem", memArr[128], 32'hBEEFAB44);

    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h208;
    req_wdata  = 32'hCAFEF00D;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rw_we", 32'(mem_we), 32'd1);
    rs0 = respCount;
    reset_n = 1'b0;
    #1;
    check("rw_mreq", 32'(mem_req), 32'd0);
    check("rw_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    noAck = 1'b0;
    repeat (3) @(negedge clock);
    check("rw_noresp", 32'(respCount - rs0), 32'd0);
    runReq(1'b0, 3'd2, 32'h204, '0, lat, d, e);
    check("post_lw_data", d, 32'hDEADBEEF);
    check("post_lw_lat", 32'(lat), 32'd2);
    check("post_lw_err", 32'(e), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
